// File: rtl/seq_detect_sched_if.sv
// Request/grant bundle between the serial requesters and the shared pattern detector.
interface seq_detect_sched_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0] req;
    logic [NCH-1:0] bit_in;
    logic [NCH-1:0] gnt;

    modport master (output req, output bit_in, input gnt);
    modport slave  (input req, input bit_in, output gnt);
endinterface

// File: rtl/seq_detect_sched.sv
// Round-robin scheduled serial pattern detector: many bit streams share one PW-bit comparator.
// Optional hit counter enabled by defining SEQ_SCHED_HITCNT_EN.
module seq_detect_sched #(
    parameter int NCH = 4,
    parameter int PW  = 3,
    parameter int CW  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_detect_sched_if.slave   bus,
    input  logic                cfg_we_i,
    input  logic [PW-1:0]       cfg_pat_i,
    output logic                hit_o,
    output logic [2:0]          hit_ch_o,
    output logic [CW-1:0]       hit_cnt_o
);
    localparam int PTRW = $clog2(NCH);
    localparam int FW   = $clog2(PW + 1);
    localparam logic [FW-1:0]   FILL_FULL = FW'(PW);
    localparam logic [PTRW-1:0] PTR_RST   = PTRW'(NCH - 1);
    localparam logic [PW-1:0]   PAT_RST   = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0]   hist_q [NCH];
    logic [PW-1:0]   hist_d [NCH];
    logic [FW-1:0]   fill_q [NCH];
    logic [FW-1:0]   fill_d [NCH];
    logic [PW-1:0]   pat_q, pat_d;
    logic [PTRW-1:0] ptr_q, ptr_d;
    logic            hit_q, hit_d;
    logic [2:0]      hit_ch_q, hit_ch_d;

    logic [NCH-1:0]  gnt_s;
    logic [PTRW-1:0] gidx_s;
    logic            gvalid_s;
    logic [PW-1:0]   new_hist_s;
    logic [FW-1:0]   new_fill_s;
    logic            match_s;

    // Round-robin search beginning just after the last granted channel; config writes stall grants.
    always_comb begin
        int             cand;
        logic [PTRW-1:0] cidx;
        cand     = 0;
        cidx     = ptr_q;
        gnt_s    = {NCH{1'b0}};
        gidx_s   = ptr_q;
        gvalid_s = 1'b0;
        if (rst_n && !cfg_we_i) begin
            for (int k = 1; k <= NCH; k++) begin
                cand = (int'(ptr_q) + k) % NCH;
                cidx = PTRW'(cand);
                if (!gvalid_s && bus.req[cidx]) begin
                    gvalid_s = 1'b1;
                    gidx_s   = cidx;
                end else begin
                    gvalid_s = gvalid_s;
                end
            end
            if (gvalid_s) begin
                gnt_s[gidx_s] = 1'b1;
            end else begin
                gnt_s = {NCH{1'b0}};
            end
        end else begin
            gnt_s = {NCH{1'b0}};
        end
    end

    assign bus.gnt = gnt_s;

    // Shared comparator: evaluate the granted channel's history after this bit shifts in.
    always_comb begin
        new_hist_s = (hist_q[gidx_s] << 1) | {{(PW-1){1'b0}}, bus.bit_in[gidx_s]};
        if (fill_q[gidx_s] == FILL_FULL) begin
            new_fill_s = FILL_FULL;
        end else begin
            new_fill_s = fill_q[gidx_s] + FW'(1);
        end
        match_s = gvalid_s && (new_hist_s == pat_q) && (new_fill_s == FILL_FULL);
    end

    // Next-state for pattern, pointer, per-channel history and the registered hit pulse.
    always_comb begin
        pat_d    = pat_q;
        ptr_d    = ptr_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        hit_d    = 1'b0;
        hit_ch_d = hit_ch_q;
        if (cfg_we_i) begin
            pat_d = cfg_pat_i;
            for (int k = 0; k < NCH; k++) begin
                hist_d[k] = {PW{1'b0}};
                fill_d[k] = {FW{1'b0}};
            end
        end else if (gvalid_s) begin
            hist_d[gidx_s] = new_hist_s;
            fill_d[gidx_s] = new_fill_s;
            ptr_d          = gidx_s;
            hit_d          = match_s;
            if (match_s) begin
                hit_ch_d = 3'(gidx_s);
            end else begin
                hit_ch_d = hit_ch_q;
            end
        end else begin
            hit_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_q    <= PAT_RST;
            ptr_q    <= PTR_RST;
            hit_q    <= 1'b0;
            hit_ch_q <= 3'd0;
            for (int k = 0; k < NCH; k++) begin
                hist_q[k] <= {PW{1'b0}};
                fill_q[k] <= {FW{1'b0}};
            end
        end else begin
            pat_q    <= pat_d;
            ptr_q    <= ptr_d;
            hit_q    <= hit_d;
            hit_ch_q <= hit_ch_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
        end
    end

    assign hit_o    = hit_q;
    assign hit_ch_o = hit_ch_q;

`ifdef SEQ_SCHED_HITCNT_EN
    logic [CW-1:0] cnt_q, cnt_d;

    // Saturating match counter; updates on the same edge that registers the hit pulse.
    always_comb begin
        cnt_d = cnt_q;
        if (match_s && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_cnt_o = cnt_q;
`else
    assign hit_cnt_o = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed self-checking bench for seq_detect_sched (NCH=4, PW=3, CW=2 to reach counter saturation).
module tb_seq_detect_sched;
    localparam int NCH = 4;
    localparam int PW  = 3;
    localparam int CW  = 2;
`ifdef SEQ_SCHED_HITCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_we;
    logic [PW-1:0]   cfg_pat;
    logic            hit;
    logic [2:0]      hit_ch;
    logic [CW-1:0]   hit_cnt;
    int              n_cmp = 0;
    int              n_bad = 0;

    always #5 clk = ~clk;

    seq_detect_sched_if #(.NCH(NCH)) bus ();

    seq_detect_sched #(.NCH(NCH), .PW(PW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cfg_we_i  (cfg_we),
        .cfg_pat_i (cfg_pat),
        .hit_o     (hit),
        .hit_ch_o  (hit_ch),
        .hit_cnt_o (hit_cnt)
    );

    function automatic logic [CW-1:0] exp_cnt(input int n);
        if (!CNT_EN) return 2'd0;
        return (n > 3) ? 2'd3 : 2'(n);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NCH-1:0] r, input logic [NCH-1:0] b);
        bus.req    = r;
        bus.bit_in = b;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        cfg_we  = 1'b0;
        cfg_pat = 3'b000;
        drive(4'b0000, 4'b0000);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        cfg_we  = 1'b0;
        cfg_pat = 3'b000;
        drive(4'b1111, 4'b0000);
        @(negedge clk);
        n_cmp++;
        if (bus.gnt !== 4'b0000) begin
            n_bad++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt);
        end
        tick();
        tick();
        n_cmp++;
        if (hit !== 1'b0 || hit_ch !== 3'd0 || hit_cnt !== 2'd0) begin
            n_bad++; $display("FAIL reset_outs: got hit=%b ch=%0d cnt=%0d expected 0/0/0", hit, hit_ch, hit_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.gnt !== 4'b0001) begin
            n_bad++; $display("FAIL reset_first_prio: got %b expected 0001", bus.gnt);
        end
        drive(4'b0000, 4'b0000);
    endtask

    task automatic test_basic_match();
        logic b [3] = '{1'b0, 1'b0, 1'b1};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(4'b0001, {3'b000, b[k]});
            @(negedge clk);
            n_cmp++;
            if (bus.gnt !== 4'b0001) begin
                n_bad++; $display("FAIL basic_gnt%0d: got %b expected 0001", k, bus.gnt);
            end
            tick();
            n_cmp++;
            if (hit !== (k == 2)) begin
                n_bad++; $display("FAIL basic_hit%0d: got %b expected %b", k, hit, (k == 2));
            end
        end
        n_cmp++;
        if (hit_ch !== 3'd0 || hit_cnt !== exp_cnt(1)) begin
            n_bad++; $display("FAIL basic_ch_cnt: got ch=%0d cnt=%0d expected 0/%0d", hit_ch, hit_cnt, exp_cnt(1));
        end
        drive(4'b0000, 4'b0000);
        tick();
        n_cmp++;
        if (hit !== 1'b0) begin
            n_bad++; $display("FAIL basic_pulse_len: got %b expected 0", hit);
        end
    endtask

    task automatic test_round_robin();
        logic [NCH-1:0] eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        drive(4'b1111, 4'b1111);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.gnt !== eg[k]) begin
                n_bad++; $display("FAIL rr_gnt%0d: got %b expected %b", k, bus.gnt, eg[k]);
            end
            tick();
            n_cmp++;
            if (hit !== 1'b0) begin
                n_bad++; $display("FAIL rr_nohit%0d: got %b expected 0", k, hit);
            end
        end
        drive(4'b0000, 4'b0000);
    endtask

    task automatic test_back_to_back();
        logic [NCH-1:0] rq [6] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b1000};
        logic           bv [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic           eh [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]     ec [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd3};
        int             en [6] = '{0, 0, 0, 0, 1, 2};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(rq[k], bv[k] ? rq[k] : 4'b0000);
            @(negedge clk);
            n_cmp++;
            if (bus.gnt !== rq[k]) begin
                n_bad++; $display("FAIL b2b_gnt%0d: got %b expected %b", k, bus.gnt, rq[k]);
            end
            tick();
            n_cmp++;
            if (hit !== eh[k] || (eh[k] && hit_ch !== ec[k]) || hit_cnt !== exp_cnt(en[k])) begin
                n_bad++; $display("FAIL b2b_hit%0d: got hit=%b ch=%0d cnt=%0d expected %b/%0d/%0d",
                                  k, hit, hit_ch, hit_cnt, eh[k], ec[k], exp_cnt(en[k]));
            end
        end
        drive(4'b0000, 4'b0000);
    endtask

    task automatic test_cfg_overlap();
        logic b  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic eh [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int   en [5] = '{0, 0, 1, 1, 2};
        logic c2 [2] = '{1'b0, 1'b1};
        do_reset();
        cfg_we  = 1'b1;
        cfg_pat = 3'b101;
        drive(4'b1111, 4'b1111);
        @(negedge clk);
        n_cmp++;
        if (bus.gnt !== 4'b0000) begin
            n_bad++; $display("FAIL cfg_gnt: got %b expected 0000", bus.gnt);
        end
        tick();
        cfg_we = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(4'b0100, {1'b0, b[k], 2'b00});
            @(negedge clk);
            n_cmp++;
            if (bus.gnt !== 4'b0100) begin
                n_bad++; $display("FAIL ovl_gnt%0d: got %b expected 0100", k, bus.gnt);
            end
            tick();
            n_cmp++;
            if (hit !== eh[k] || (eh[k] && hit_ch !== 3'd2) || hit_cnt !== exp_cnt(en[k])) begin
                n_bad++; $display("FAIL ovl_hit%0d: got hit=%b ch=%0d cnt=%0d expected %b/2/%0d",
                                  k, hit, hit_ch, hit_cnt, eh[k], exp_cnt(en[k]));
            end
        end
        // Config write in the cycle right after a match: the registered pulse stays visible.
        cfg_we = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.gnt !== 4'b0000 || hit !== 1'b1 || hit_cnt !== exp_cnt(2)) begin
            n_bad++; $display("FAIL cfg_coincident: got gnt=%b hit=%b cnt=%0d expected 0000/1/%0d",
                              bus.gnt, hit, hit_cnt, exp_cnt(2));
        end
        tick();
        cfg_we = 1'b0;
        n_cmp++;
        if (hit !== 1'b0 || hit_cnt !== exp_cnt(2)) begin
            n_bad++; $display("FAIL cfg_after: got hit=%b cnt=%0d expected 0/%0d", hit, hit_cnt, exp_cnt(2));
        end
        for (int k = 0; k < 2; k++) begin
            drive(4'b0100, {1'b0, c2[k], 2'b00});
            tick();
            n_cmp++;
            if (hit !== 1'b0) begin
                n_bad++; $display("FAIL cfg_cleared%0d: got %b expected 0", k, hit);
            end
        end
        drive(4'b0000, 4'b0000);
    endtask

    task automatic test_short_fill();
        do_reset();
        drive(4'b0001, 4'b0001);
        tick();
        n_cmp++;
        if (hit !== 1'b0) begin
            n_bad++; $display("FAIL short_fill: got %b expected 0", hit);
        end
        drive(4'b0000, 4'b0000);
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(4'b0001, 4'b0000);
        tick();
        tick();
        rst_n = 1'b0;
        drive(4'b0001, 4'b0001);
        @(negedge clk);
        n_cmp++;
        if (bus.gnt !== 4'b0000) begin
            n_bad++; $display("FAIL midrst_gnt: got %b expected 0000", bus.gnt);
        end
        tick();
        n_cmp++;
        if (hit !== 1'b0) begin
            n_bad++; $display("FAIL midrst_hit: got %b expected 0", hit);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (hit !== 1'b0) begin
            n_bad++; $display("FAIL midrst_discard: got %b expected 0", hit);
        end
        drive(4'b0000, 4'b0000);
    endtask

    task automatic test_saturate();
        int m;
        do_reset();
        cfg_we  = 1'b1;
        cfg_pat = 3'b111;
        tick();
        cfg_we = 1'b0;
        drive(4'b0001, 4'b0001);
        for (int k = 1; k <= 7; k++) begin
            tick();
            m = (k >= 3) ? (k - 2) : 0;
            n_cmp++;
            if (hit !== (k >= 3) || hit_cnt !== exp_cnt(m)) begin
                n_bad++; $display("FAIL sat_%0d: got hit=%b cnt=%0d expected %b/%0d",
                                  k, hit, hit_cnt, (k >= 3), exp_cnt(m));
            end
        end
        drive(4'b0000, 4'b0000);
    endtask

    initial begin
        test_reset();
        test_basic_match();
        test_round_robin();
        test_back_to_back();
        test_cfg_overlap();
        test_short_fill();
        test_mid_reset();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
